i2c_master_wr: RTL and testbench
================================

I2C_MASTER_WR -- requirements
Module: i2c_master_wr

Interface
REQ-001 SHALL have parameter ADDRESS, default 7'h4A: 7-bit target address, always sent with R/W=0.
REQ-002 SHALL have parameter QUARTER, default 62: clk cycles per quarter SCL bit period, minimum 2.
REQ-003 SHALL have port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port scl_i, input, 1: sampled SCL line level.
REQ-006 SHALL have port scl_o, output, 1: SCL drive; 0 = pull low, 1 = release.
REQ-007 SHALL have port sda_i, input, 1: sampled SDA line level, used for ACK.
REQ-008 SHALL have port sda_o, output, 1: SDA drive; 0 = pull low, 1 = release.
REQ-009 SHALL have port data_i, input, 8: byte to transmit, MSB first.
REQ-010 SHALL have port data_valid_i, input, 1: data_i is valid.
REQ-011 SHALL have port last_i, input, 1: qualifies the accepted byte as the final byte of the transaction.
REQ-012 SHALL have port data_ready_o, output, 1: the block can accept a byte.
REQ-013 SHALL have port busy_o, output, 1: a transaction is in progress (any state except IDLE).
REQ-014 SHALL have port nack_o, output, 1: sticky flag; the target NACKed in the last transaction.

Function
REQ-015 SHALL implement the states IDLE, START, ADDR, ACK, DATA, WAIT and STOP.
REQ-016 SHALL accept a byte, together with last_i, into an internal buffer on any clk edge where data_valid_i and data_ready_o are both 1.
REQ-017 SHALL drive data_ready_o to 1 only in IDLE and WAIT; data_ready_o is a combinational function of state.
REQ-018 SHALL, on acceptance in IDLE, clear nack_o and enter START on the next clk.
REQ-019 SHALL perform START as: SDA and SCL released for 1 quarter, then SDA=0 for 1 quarter, then SCL=0 for 1 quarter, then enter ADDR.
REQ-020 SHALL send each bit (ADDR, DATA and the ACK slot) as 4 quarters: Q0 SCL=0 with SDA updated at Q0 entry; Q1 SCL=0; Q2 SCL released; Q3 SCL released; then back to SCL=0.
REQ-021 SHALL implement clock stretching: while scl_o=1 and scl_i=0 in Q2, the quarter counter SHALL hold.
REQ-022 SHALL send ADDR as {ADDRESS,1'b0}, bit 7 first, then enter ACK.
REQ-023 SHALL release SDA in the ACK slot and sample sda_i on the last clk of its Q2.
REQ-024 SHALL, on a sampled ACK of 0 after the address, enter DATA with the buffered byte.
REQ-025 SHALL, on a sampled ACK of 0 after data, enter STOP if the buffered last flag is 1, otherwise enter WAIT.
REQ-026 SHALL, on a sampled ACK of 1 in any slot, set nack_o, discard the buffer and enter STOP.
REQ-027 SHALL, in WAIT, hold SCL=0 and SDA=0 indefinitely, and on acceptance enter DATA on the next clk.
REQ-028 SHALL perform STOP as: SCL=0/SDA=0 for 1 quarter; SCL released for 1 quarter; SDA released for 1 quarter; then 1 bus-free quarter; then enter IDLE.
REQ-029 SHALL change SDA only while SCL is low, except in START and STOP.
REQ-030 SHALL ignore data_valid_i when data_ready_o=0; no byte is lost or duplicated.
REQ-031 SHALL keep a quarter counter wide enough for QUARTER-1 and reset it to 0 at every quarter boundary.

Reset
REQ-032 SHALL, while reset=0, force state=IDLE, scl_o=1, sda_o=1, busy_o=0, nack_o=0, counters=0 and buffer=0.
REQ-033 SHALL, when reset is asserted mid-transaction, release both lines immediately without generating a STOP; the next transaction begins with a fresh START.
REQ-034 SHALL drive data_ready_o=1 while in reset, since the state is IDLE.

Verification
REQ-035 Bench SHALL cover single byte: accept 8'hAB with last_i=1, target ACKs -> START, SDA bit pattern 1001010 0, ACK, 10101011, ACK, STOP; busy_o returns to 0; nack_o=0.
REQ-036 Bench SHALL cover multi-byte: bytes 8'h00, 8'h36, 8'h0D (last on 8'h0D) with data_valid_i gaps of 1000 clk -> SCL held low in WAIT during the gaps; exactly 3 data bytes on the bus with a single START and a single STOP.
REQ-037 Bench SHALL cover address NACK: sda_i=1 in the address ACK slot -> nack_o=1, no data bits sent, STOP, IDLE; nack_o clears on the next accepted byte.
REQ-038 Bench SHALL cover clock stretching: scl_i forced low for 500 clk during Q2 of bit 3 -> SCL-high duration unaffected after release; total transaction length +500 clk.
REQ-039 Bench SHALL cover reset mid-DATA: reset=0 at bit 4 -> scl_o=1, sda_o=1 and busy_o=0 asynchronously; a subsequent byte yields a complete, correct transaction.
REQ-040 Bench SHALL cover loopback: pair with the existing I2C receiver (address 7'h4A) -> the receiver reports address_valid, then data 8'hAB, 8'h36, 8'h84 in order.

Source files
------------

// File: rtl/i2c_master_wr.sv
// rtl/i2c_master_wr.sv - single-target I2C write master with one-byte buffer and clock stretching
module i2c_master_wr #(
    parameter logic [6:0] ADDRESS = 7'h4A,
    parameter int         QUARTER = 62
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    output logic       scl_o,
    input  logic       sda_i,
    output logic       sda_o,
    input  logic [7:0] data_i,
    input  logic       data_valid_i,
    input  logic       last_i,
    output logic       data_ready_o,
    output logic       busy_o,
    output logic       nack_o
);

    localparam int CW = (QUARTER > 2) ? $clog2(QUARTER) : 1;
    localparam logic [CW-1:0] QLAST = CW'(QUARTER - 1);

    typedef enum logic [2:0] {IDLE, START, ADDR, ACK, DATA, WAIT, STOP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   qcnt_q, qcnt_d;
    logic [1:0]      phase_q, phase_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      buf_q, buf_d;
    logic            last_q, last_d;
    logic            nack_q, nack_d;
    logic            addr_slot_q, addr_slot_d;
    logic            ack_q, ack_d;

    logic            accept;
    logic            bit_state;
    logic            stretch;
    logic            tick;

    assign data_ready_o = (state_q == IDLE) || (state_q == WAIT);
    assign busy_o       = (state_q != IDLE);
    assign nack_o       = nack_q;
    assign accept       = data_valid_i && data_ready_o;
    assign bit_state    = (state_q == ADDR) || (state_q == ACK) || (state_q == DATA);
    // a target holding SCL low while we release it freezes the high half of the bit
    assign stretch      = bit_state && (phase_q == 2'd2) && scl_o && !scl_i;
    assign tick         = (qcnt_q == QLAST) && !stretch;

    // line levels are a pure function of state, quarter phase and the outgoing bit
    always_comb begin
        scl_o = 1'b1;
        sda_o = 1'b1;
        case (state_q)
            IDLE: begin
                scl_o = 1'b1;
                sda_o = 1'b1;
            end
            START: begin
                scl_o = (phase_q < 2'd2);
                sda_o = (phase_q == 2'd0);
            end
            ADDR, DATA: begin
                scl_o = phase_q[1];
                sda_o = shift_q[7];
            end
            ACK: begin
                scl_o = phase_q[1];
                sda_o = 1'b1;
            end
            WAIT: begin
                scl_o = 1'b0;
                sda_o = 1'b0;
            end
            STOP: begin
                scl_o = (phase_q != 2'd0);
                sda_o = phase_q[1];
            end
            default: begin
                scl_o = 1'b1;
                sda_o = 1'b1;
            end
        endcase
    end

    // quarter timing, bit sequencing and byte buffering
    always_comb begin
        state_d     = state_q;
        qcnt_d      = qcnt_q;
        phase_d     = phase_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        buf_d       = buf_q;
        last_d      = last_q;
        nack_d      = nack_q;
        addr_slot_d = addr_slot_q;
        ack_d       = ack_q;

        if (state_q == IDLE || state_q == WAIT) begin
            qcnt_d = '0;
        end else if (stretch) begin
            qcnt_d = qcnt_q;
        end else if (tick) begin
            qcnt_d  = '0;
            phase_d = phase_q + 2'd1;
        end else begin
            qcnt_d = qcnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    buf_d    = data_i;
                    last_d   = last_i;
                    nack_d   = 1'b0;
                    shift_d  = {ADDRESS, 1'b0};
                    bitcnt_d = 3'd0;
                    phase_d  = 2'd0;
                    state_d  = START;
                end
            end
            START: begin
                if (tick && phase_q == 2'd2) begin
                    phase_d = 2'd0;
                    state_d = ADDR;
                end
            end
            ADDR, DATA: begin
                if (tick && phase_q == 2'd3) begin
                    shift_d  = {shift_q[6:0], 1'b0};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        addr_slot_d = (state_q == ADDR);
                        state_d     = ACK;
                    end
                end
            end
            ACK: begin
                if (tick && phase_q == 2'd2) begin
                    ack_d = sda_i;
                end
                if (tick && phase_q == 2'd3) begin
                    if (ack_q) begin
                        nack_d  = 1'b1;
                        buf_d   = 8'h00;
                        last_d  = 1'b0;
                        state_d = STOP;
                    end else if (addr_slot_q) begin
                        shift_d = buf_q;
                        state_d = DATA;
                    end else if (last_q) begin
                        state_d = STOP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (accept) begin
                    buf_d   = data_i;
                    last_d  = last_i;
                    shift_d = data_i;
                    phase_d = 2'd0;
                    state_d = DATA;
                end
            end
            STOP: begin
                if (tick && phase_q == 2'd3) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state register; reset drops the bus immediately without a STOP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            qcnt_q      <= '0;
            phase_q     <= 2'd0;
            bitcnt_q    <= 3'd0;
            shift_q     <= 8'h00;
            buf_q       <= 8'h00;
            last_q      <= 1'b0;
            nack_q      <= 1'b0;
            addr_slot_q <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            qcnt_q      <= qcnt_d;
            phase_q     <= phase_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            buf_q       <= buf_d;
            last_q      <= last_d;
            nack_q      <= nack_d;
            addr_slot_q <= addr_slot_d;
            ack_q       <= ack_d;
        end
    end

endmodule

// File: tb/tb_i2c_master_wr.sv
// tb/tb_i2c_master_wr.sv - scoreboard bench for i2c_master_wr with bus decoder and target model
module tb_i2c_master_wr;

    localparam int          Q        = 5;
    localparam logic [6:0]  TADDR    = 7'h4A;
    localparam logic [31:0] EV_START = 32'h100;
    localparam logic [31:0] EV_STOP  = 32'h200;

    logic       clk;
    logic       reset;
    logic       scl_o, sda_o;
    logic       scl_bus, sda_bus;
    logic [7:0] data_i;
    logic       data_valid_i, last_i;
    logic       data_ready_o, busy_o, nack_o;
    logic       hold_scl, tgt_low;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  txb[$];
    int          nack_at = -1;
    int          busy_cycles;
    int          high_len;

    assign scl_bus = scl_o & ~hold_scl;
    assign sda_bus = sda_o & ~tgt_low;

    i2c_master_wr #(.ADDRESS(TADDR), .QUARTER(Q)) dut (
        .clk          (clk),
        .reset        (reset),
        .scl_i        (scl_bus),
        .scl_o        (scl_o),
        .sda_i        (sda_bus),
        .sda_o        (sda_o),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .last_i       (last_i),
        .data_ready_o (data_ready_o),
        .busy_o       (busy_o),
        .nack_o       (nack_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_note(input string name);
        total++;
        bad++;
        $display("FAIL %s: actual=timeout required=event", name);
    endtask

    function automatic logic [31:0] byte_ev(input logic [7:0] b, input logic a);
        return 32'h400 | {23'd0, b, a};
    endfunction

    function automatic int exp_cycles(input int nb);
        return (3 + 36 * (nb + 1) + 4) * Q;
    endfunction

    task automatic pop_check(input logic [31:0] ev);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL bus_event: actual=%0h required=none", ev);
        end else begin
            check("bus_event", ev, exp_q.pop_front());
        end
    endtask

    // bus decoder plus ACKing target: turns line activity into START/byte/STOP events
    logic       scl_p = 1'b1, sda_p = 1'b1;
    bit         in_frame = 1'b0;
    int         tbits = 0, byte_idx = 0;
    logic [8:0] msh = '0;
    always @(negedge clk) begin
        logic s, d;
        s = scl_bus;
        d = sda_bus;
        if (scl_p && s && sda_p && !d) begin
            in_frame = 1'b1;
            tbits    = 0;
            byte_idx = 0;
            tgt_low  = 1'b0;
            pop_check(EV_START);
        end else if (scl_p && s && !sda_p && d) begin
            in_frame = 1'b0;
            tgt_low  = 1'b0;
            pop_check(EV_STOP);
        end else if (!scl_p && s && in_frame) begin
            msh = {msh[7:0], d};
            tbits++;
            if (tbits == 9) pop_check(byte_ev(msh[8:1], msh[0]));
        end else if (scl_p && !s && in_frame) begin
            if (tbits == 8) begin
                tgt_low = (nack_at != byte_idx);
            end else if (tbits == 9) begin
                tgt_low  = 1'b0;
                tbits    = 0;
                byte_idx++;
            end
        end
        scl_p = s;
        sda_p = d;
    end

    // present one byte from a negedge and hold it until the DUT takes it
    task automatic send(input logic [7:0] b, input logic l);
        int t = 0;
        data_i       = b;
        last_i       = l;
        data_valid_i = 1'b1;
        while (!data_ready_o && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (!data_ready_o) begin
            fail_note("accept");
            data_valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        data_valid_i = 1'b0;
    endtask

    // queue the expected bus events for txb, then drive it; nk = byte slot the target NACKs
    task automatic run_txn(input int nk, input int gap);
        int n = txb.size();
        int nsend;
        nsend   = (nk < 0) ? n : ((nk == 0) ? 1 : nk);
        nack_at = nk;
        exp_q.push_back(EV_START);
        exp_q.push_back(byte_ev({TADDR, 1'b0}, nk == 0));
        if (nk != 0)
            for (int j = 0; j < nsend; j++) exp_q.push_back(byte_ev(txb[j], nk == j + 1));
        exp_q.push_back(EV_STOP);
        send(txb[0], n == 1);
        busy_cycles = 0;
        fork
            begin
                while (busy_o && busy_cycles < 50000) begin
                    busy_cycles++;
                    @(negedge clk);
                end
                if (busy_o) fail_note("busy_end");
            end
            begin
                for (int j = 1; j < nsend; j++) begin
                    for (int k = 0; k < gap; k++) begin
                        @(negedge clk);
                        if (gap >= 1000 && k == 700) begin
                            check("wait_scl_low", scl_o, 1'b0);
                            check("wait_sda_low", sda_o, 1'b0);
                            check("wait_ready", data_ready_o, 1'b1);
                        end
                    end
                    send(txb[j], j == n - 1);
                end
            end
        join
    endtask

    task automatic wait_scl_rises(input int n);
        int   c = 0, t = 0;
        logic p;
        p = scl_o;
        while (c < n && t < 20000) begin
            @(negedge clk);
            t++;
            if (!p && scl_o) c++;
            p = scl_o;
        end
        if (c < n) fail_note("scl_rise");
    endtask

    task automatic wait_scl_level(input logic v);
        int t = 0;
        while (scl_o !== v && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (scl_o !== v) fail_note("scl_level");
    endtask

    initial begin
        reset        = 1'b0;
        data_i       = 8'h00;
        data_valid_i = 1'b0;
        last_i       = 1'b0;
        hold_scl     = 1'b0;
        tgt_low      = 1'b0;
        #1;
        check("rst_scl", scl_o, 1'b1);
        check("rst_sda", sda_o, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        check("rst_nack", nack_o, 1'b0);
        check("rst_ready", data_ready_o, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // single byte 0xAB, fully acknowledged
        txb.delete(); txb.push_back(8'hAB);
        run_txn(-1, 0);
        check("single_len", busy_cycles, exp_cycles(1));
        check("single_busy", busy_o, 1'b0);
        check("single_nack", nack_o, 1'b0);

        // three bytes with long pauses: bus parked in WAIT between them
        txb.delete(); txb.push_back(8'h00); txb.push_back(8'h36); txb.push_back(8'h0D);
        run_txn(-1, 1000);
        check("multi_nack", nack_o, 1'b0);

        // address NACK, then a clean transaction must clear the flag
        txb.delete(); txb.push_back(8'h11);
        run_txn(0, 0);
        check("addr_nack_flag", nack_o, 1'b1);
        check("addr_nack_busy", busy_o, 1'b0);
        txb.delete(); txb.push_back(8'h22);
        run_txn(-1, 0);
        check("nack_cleared", nack_o, 1'b0);

        // data NACK on the first of two bytes ends the transaction early
        txb.delete(); txb.push_back(8'h77); txb.push_back(8'h88);
        run_txn(1, 0);
        check("data_nack_flag", nack_o, 1'b1);

        // clock stretching of 500 clk at the high phase of address bit 3
        txb.delete(); txb.push_back(8'h5A);
        high_len = 0;
        fork
            run_txn(-1, 0);
            begin
                wait_scl_rises(3);
                wait_scl_level(1'b0);
                hold_scl = 1'b1;
                wait_scl_level(1'b1);
                repeat (500) @(negedge clk);
                hold_scl = 1'b0;
                #1;
                while (scl_bus && high_len < 1000) begin
                    high_len++;
                    @(negedge clk);
                end
            end
        join
        check("stretch_len", busy_cycles, exp_cycles(1) + 500);
        check("stretch_high", high_len, 2 * Q);

        // asynchronous reset in the middle of data bit 4
        nack_at = -1;
        exp_q.push_back(EV_START);
        exp_q.push_back(byte_ev({TADDR, 1'b0}, 1'b0));
        send(8'hC3, 1'b1);
        wait_scl_rises(13);
        wait_scl_level(1'b0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_scl", scl_o, 1'b1);
        check("midrst_sda", sda_o, 1'b1);
        check("midrst_busy", busy_o, 1'b0);
        @(negedge clk);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        txb.delete(); txb.push_back(8'h3C);
        run_txn(-1, 0);
        check("postrst_len", busy_cycles, exp_cycles(1));

        // three-byte stream received in order
        txb.delete(); txb.push_back(8'hAB); txb.push_back(8'h36); txb.push_back(8'h84);
        run_txn(-1, 0);

        // randomized transactions
        for (int it = 0; it < 6; it++) begin
            int n, nk, gap;
            n = int'($urandom_range(1, 3));
            txb.delete();
            for (int j = 0; j < n; j++) txb.push_back(8'($urandom));
            nk  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n)) : -1;
            gap = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 60)) : 0;
            run_txn(nk, gap);
            check("rand_nack", nack_o, (nk >= 0) ? 1'b1 : 1'b0);
            if (nk < 0 && n == 1) check("rand_len", busy_cycles, exp_cycles(1));
        end

        repeat (10) @(negedge clk);
        check("exp_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
